// File: rtl/rvv_backend_vrf_read_responder_pkg.sv
// Shared definitions for the VRF read responder: read-port count, index
// width, vector length and the response FIFO entry type.
// Build option: define VRF_RD_BYPASS_EN to merge same-cycle writebacks into read data.
package rvv_backend_vrf_read_responder_pkg;

  localparam int NUM_DP_VRF          = 6;
  localparam int REGFILE_INDEX_WIDTH = 5;
  localparam int VLEN                = 128;
  localparam int NREG                = 32;

  // One queued response bundle: echoed enables plus per-port read data.
  typedef struct packed {
    logic [NUM_DP_VRF-1:0]           port_en;
    logic [NUM_DP_VRF-1:0][VLEN-1:0] data;
  } VRF_RD_RESP_t;

endpackage

// File: rtl/rvv_backend_vrf_rd_merge.sv
// Single VRF read port: selects one register from the flat VRF image and,
// when VRF_RD_BYPASS_EN is defined, overlays the strobed bytes of a
// same-cycle writeback to that register. A disabled port returns zero.
module rvv_backend_vrf_rd_merge #(
  parameter int IDXW = 5,
  parameter int NREG = 32,
  parameter int VLEN = 128
) (
  input  logic                 i_en,
  input  logic [IDXW-1:0]      i_rd_index,
  input  logic [NREG*VLEN-1:0] i_vrf_data,
  input  logic                 i_wb_valid,
  input  logic [IDXW-1:0]      i_wb_index,
  input  logic [VLEN/8-1:0]    i_wb_strb,
  input  logic [VLEN-1:0]      i_wb_data,
  output logic [VLEN-1:0]      o_data
);

  logic [VLEN-1:0] w_regs [NREG];
  logic [VLEN-1:0] w_sel;
  logic [VLEN-1:0] w_merged;

  for (genvar r = 0; r < NREG; r++) begin : g_regs
    assign w_regs[r] = i_vrf_data[r*VLEN +: VLEN];
  end

  assign w_sel = w_regs[i_rd_index];

`ifdef VRF_RD_BYPASS_EN
  logic w_hit;
  assign w_hit = i_wb_valid && (i_wb_index == i_rd_index);

  // Byte-wise overlay of the writeback onto the selected register.
  always_comb begin
    w_merged = w_sel;
    for (int i = 0; i < VLEN/8; i++) begin
      if (w_hit && i_wb_strb[i]) begin
        w_merged[i*8 +: 8] = i_wb_data[i*8 +: 8];
      end else begin
        w_merged[i*8 +: 8] = w_sel[i*8 +: 8];
      end
    end
  end
`else
  // Writeback is not forwarded; dispatch stalls read-after-write collisions.
  logic w_unused_wb;
  assign w_unused_wb = ^{i_wb_valid, i_wb_index, i_wb_strb, i_wb_data};

  // Plain register read.
  always_comb begin
    w_merged = w_sel;
  end
`endif

  // Disabled ports deliver zero so unused lanes carry no stale data.
  always_comb begin
    if (i_en) begin
      o_data = w_merged;
    end else begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/rvv_backend_vrf_read_responder.sv
// VRF read responder: captures one read bundle per accepted cycle (with
// optional writeback byte-merge, enabled by defining VRF_RD_BYPASS_EN) into a
// small response FIFO so operand delivery can be back-pressured without
// re-reading the VRF. The entry type comes from the package, so NUM_PORT and
// VLEN are expected to match the package values.
module rvv_backend_vrf_read_responder #(
  parameter int NUM_PORT = rvv_backend_vrf_read_responder_pkg::NUM_DP_VRF,
  parameter int IDXW     = rvv_backend_vrf_read_responder_pkg::REGFILE_INDEX_WIDTH,
  parameter int NREG     = rvv_backend_vrf_read_responder_pkg::NREG,
  parameter int VLEN     = rvv_backend_vrf_read_responder_pkg::VLEN,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_PORT-1:0]      req_port_en,
  input  logic [NUM_PORT*IDXW-1:0] rd_index,
  input  logic [NREG*VLEN-1:0]     vrf_data,
  input  logic                     wb_valid,
  input  logic [IDXW-1:0]          wb_index,
  input  logic [VLEN/8-1:0]        wb_strb,
  input  logic [VLEN-1:0]          wb_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [NUM_PORT-1:0]      resp_port_en,
  output logic [NUM_PORT*VLEN-1:0] resp_data
);

  import rvv_backend_vrf_read_responder_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [NUM_PORT-1:0][VLEN-1:0] w_port_data;
  VRF_RD_RESP_t                  w_entry;
  logic                          w_push;
  logic                          w_pop;
  logic [CW-1:0]                 w_count_nxt;
  logic [PW-1:0]                 w_wptr_nxt;
  logic [PW-1:0]                 w_rptr_nxt;

  VRF_RD_RESP_t  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_req_ready;

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    rvv_backend_vrf_rd_merge #(
      .IDXW (IDXW),
      .NREG (NREG),
      .VLEN (VLEN)
    ) u_merge (
      .i_en       (req_port_en[p]),
      .i_rd_index (rd_index[p*IDXW +: IDXW]),
      .i_vrf_data (vrf_data),
      .i_wb_valid (wb_valid),
      .i_wb_index (wb_index),
      .i_wb_strb  (wb_strb),
      .i_wb_data  (wb_data),
      .o_data     (w_port_data[p])
    );
  end

  assign w_entry.port_en = req_port_en;
  assign w_entry.data    = w_port_data;

  assign w_push = req_valid && r_req_ready;
  assign w_pop  = (r_count != '0) && resp_ready;

  // Next occupancy and pointer values; pointers wrap by compare-and-clear.
  always_comb begin
    w_count_nxt = r_count;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
    if (w_push) begin
      w_wptr_nxt = (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1'b1);
    end else begin
      w_wptr_nxt = r_wptr;
    end
    if (w_pop) begin
      w_rptr_nxt = (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1'b1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
  end

  // FIFO state, entry storage and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_req_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count     <= w_count_nxt;
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_req_ready <= (w_count_nxt < DEPTH_C);
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = (r_count != '0);
  assign resp_port_en = r_mem[r_rptr].port_en;
  assign resp_data    = r_mem[r_rptr].data;

endmodule

// File: tb/tb_rvv_backend_vrf_read_responder.sv
// Directed bench for rvv_backend_vrf_read_responder: reset, basic read,
// writeback bypass (expectation follows VRF_RD_BYPASS_EN), backpressure,
// streaming with pointer wrap, and reset mid-operation.
module tb_rvv_backend_vrf_read_responder;

  localparam int NP = 6;
  localparam int IW = 5;
  localparam int NR = 32;
  localparam int VL = 128;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [NP-1:0]   req_port_en;
  logic [NP*IW-1:0] rd_index;
  logic [NR*VL-1:0] vrf_data;
  logic            wb_valid;
  logic [IW-1:0]   wb_index;
  logic [VL/8-1:0] wb_strb;
  logic [VL-1:0]   wb_data;
  logic            resp_valid;
  logic            resp_ready;
  logic [NP-1:0]   resp_port_en;
  logic [NP*VL-1:0] resp_data;

  logic [VL-1:0] vrf_m [NR];
  int n_checks;
  int n_pass;

  rvv_backend_vrf_read_responder #(
    .NUM_PORT (NP),
    .IDXW     (IW),
    .NREG     (NR),
    .VLEN     (VL),
    .DEPTH    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_port_en  (req_port_en),
    .rd_index     (rd_index),
    .vrf_data     (vrf_data),
    .wb_valid     (wb_valid),
    .wb_index     (wb_index),
    .wb_strb      (wb_strb),
    .wb_data      (wb_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_port_en (resp_port_en),
    .resp_data    (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NP*VL-1:0] act, input logic [NP*VL-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bundle from the bench's own VRF image (no writeback).
  function automatic logic [NP*VL-1:0] exp_bundle(input logic [NP-1:0] en, input logic [NP*IW-1:0] idx);
    logic [NP*VL-1:0] r;
    logic [IW-1:0] ix;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      ix = idx[p*IW +: IW];
      if (en[p]) r[p*VL +: VL] = vrf_m[ix];
    end
    return r;
  endfunction

  task automatic drive(input logic [NP-1:0] en, input logic [NP*IW-1:0] idx);
    req_valid   = 1'b1;
    req_port_en = en;
    rd_index    = idx;
  endtask

  logic [NP*VL-1:0] e_a, e_b, e_c, e_bp;
  logic [NP*IW-1:0] idx_v;
  logic [VL-1:0]    v3, v7, vbp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    v3  = {16{8'h0F}};
    v7  = {16{8'hA5}};
    for (int r = 0; r < NR; r++) vrf_m[r] = {16{8'(8'h40 + r)}};
    vrf_m[3] = v3;
    vrf_m[7] = v7;
    for (int r = 0; r < NR; r++) vrf_data[r*VL +: VL] = vrf_m[r];

    rst = 1'b1;
    wb_valid = 1'b0; wb_index = 5'd0; wb_strb = 16'h0000; wb_data = '0;
    resp_ready = 1'b0;
    drive(6'b111111, {5'd7, 5'd3, 5'd7, 5'd3, 5'd7, 5'd3});

    // Reset held with req_valid high: nothing accepted, outputs zero.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_data", resp_data, '0);
      chk("rst_req_ready", req_ready, 1'b0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_resp_valid", resp_valid, 1'b0);

    // Basic read: port0 <- v3, port1 <- v7, others disabled.
    drive(6'b000011, {5'd5, 5'd5, 5'd5, 5'd5, 5'd7, 5'd3});
    tick();
    req_valid = 1'b0;
    chk("basic_valid", resp_valid, 1'b1);
    chk("basic_en", resp_port_en, 6'b000011);
    chk("basic_data", resp_data, {{4{128'h0}}, v7, v3});
    resp_ready = 1'b1;
    tick();
    chk("basic_popped", resp_valid, 1'b0);
    resp_ready = 1'b0;

    // Same-cycle writeback to v3 with low 8 byte strobes.
    wb_valid = 1'b1; wb_index = 5'd3; wb_strb = 16'h00FF; wb_data = {16{8'hFF}};
    drive(6'b000001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3});
    tick();
    req_valid = 1'b0; wb_valid = 1'b0;
`ifdef VRF_RD_BYPASS_EN
    vbp = {{8{8'h0F}}, {8{8'hFF}}};
`else
    vbp = {16{8'h0F}};
`endif
    e_bp = '0;
    e_bp[VL-1:0] = vbp;
    chk("bypass_data", resp_data, e_bp);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Backpressure: A and B fill the FIFO, C waits.
    e_a = exp_bundle(6'b000001, {25'd0, 5'd7});
    e_b = exp_bundle(6'b000001, {25'd0, 5'd3});
    e_c = exp_bundle(6'b100001, {5'd12, 20'd0, 5'd10});
    drive(6'b000001, {25'd0, 5'd7});
    tick();
    chk("bp_ready_after_a", req_ready, 1'b1);
    drive(6'b000001, {25'd0, 5'd3});
    tick();
    chk("bp_ready_full", req_ready, 1'b0);
    drive(6'b100001, {5'd12, 20'd0, 5'd10});
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_head_stable", resp_data, e_a);
      chk("bp_hold_full", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_head_b", resp_data, e_b);
    chk("bp_ready_after_pop", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("bp_head_c_valid", resp_valid, 1'b1);
    chk("bp_head_c", resp_data, e_c);
    chk("bp_head_c_en", resp_port_en, 6'b100001);
    tick();
    chk("bp_drained", resp_valid, 1'b0);

    // Streaming: one bundle accepted and one delivered every cycle.
    for (int i = 0; i < 20; i++) begin
      idx_v = {5'(31 - i), 20'd0, 5'(i)};
      drive(6'b100001, idx_v);
      tick();
      chk("stream_valid", resp_valid, 1'b1);
      chk("stream_data", resp_data, exp_bundle(6'b100001, idx_v));
      chk("stream_ready", req_ready, 1'b1);
    end
    req_valid = 1'b0;
    tick();
    chk("stream_drained", resp_valid, 1'b0);

    // Reset mid-operation drops both queued bundles.
    resp_ready = 1'b0;
    drive(6'b000001, {25'd0, 5'd7});
    tick();
    drive(6'b000001, {25'd0, 5'd3});
    tick();
    req_valid = 1'b0;
    chk("mid_full_valid", resp_valid, 1'b1);
    chk("mid_full_ready", req_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", resp_valid, 1'b0);
    chk("mid_rst_data", resp_data, '0);
    chk("mid_rst_ready", req_ready, 1'b0);
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_stale", resp_valid, 1'b0);
      chk("mid_ready", req_ready, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
